// File: rtl/hsid_pkg.sv
// -----------------------------------------------------------------------------
// hsid_pkg
// Shared types and default widths for the HSID vector datapath.
//   hsid_op_e     : element-wise operation selector
//   hsid_state_e  : control FSM states of the streaming vector operator
//   HSID_WORD_WIDTH / HSID_HSP_BANDS_WIDTH : default element and band-count widths
// -----------------------------------------------------------------------------
package hsid_pkg;

   localparam int HSID_WORD_WIDTH      = 16;
   localparam int HSID_HSP_BANDS_WIDTH = 3;

   typedef enum logic [1:0] {
      HSID_OP_ADD      = 2'd0,
      HSID_OP_SUB      = 2'd1,
      HSID_OP_ABS_DIFF = 2'd2,
      HSID_OP_SQ_DIFF  = 2'd3
   } hsid_op_e;

   typedef enum logic [1:0] {
      HSID_ST_IDLE    = 2'd0,
      HSID_ST_COMPUTE = 2'd1,
      HSID_ST_DONE    = 2'd2
   } hsid_state_e;

endpackage

// File: rtl/hsid_fifo.sv
// -----------------------------------------------------------------------------
// hsid_fifo
// Synchronous FIFO, depth 2**ADDR_W, with registered read data and registered
// full/empty flags.
//   clk, rst   : clock, synchronous active-high reset (flushes the FIFO)
//   wr_en_i    : write strobe; a write while full is dropped
//   wr_data_i  : write data
//   rd_en_i    : read strobe; a read while empty is ignored
//   rd_data_o  : head word, loaded on an accepted read, otherwise held
//   full_o     : FIFO full
//   empty_o    : FIFO empty
// -----------------------------------------------------------------------------
module hsid_fifo #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
   logic              wr_ok;
   logic              rd_ok;

   // Flags are registered, so accept/reject decisions use last cycle's flags.
   assign wr_ok = wr_en_i && !full_q;
   assign rd_ok = rd_en_i && !empty_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      cnt_d     = cnt_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      cnt_d   = cnt_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
      full_d  = (cnt_d == (ADDR_W+1)'(DEPTH));
      empty_d = (cnt_d == '0);
   end

   // Storage is not reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;
   assign full_o    = full_q;
   assign empty_o   = empty_q;

endmodule

// File: rtl/vctr_fifo_strm_op.sv
// -----------------------------------------------------------------------------
// vctr_fifo_strm_op
// Streaming two-vector element-wise operator (ADD, SUB, ABS_DIFF, SQ_DIFF) with
// optional reduction of the whole vector into one accumulated word.
// Two input FIFOs feed a two-stage pipeline (operand pop, compute/push) that
// writes an output FIFO.
//   clk, rst                         : clock, synchronous active-high reset
//   data_in_v1_en/data_in_v1/_full   : vector 1 element write port
//   data_in_v2_en/data_in_v2/_full   : vector 2 element write port
//   data_out_en/data_out/_empty      : result read port (registered read data)
//   vector_length                    : element count, 0 means 2**HSP_BANDS_WIDTH
//   mode, acc_en                     : operation and reduction enable, sampled on start
//   start                            : start request, honoured only when idle
//   done, idle, ready                : status
// -----------------------------------------------------------------------------
module vctr_fifo_strm_op
   import hsid_pkg::*;
#(
   parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
   parameter int HSP_BANDS_WIDTH = HSID_HSP_BANDS_WIDTH,
   parameter int BUFFER_WIDTH    = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     data_in_v1_en,
   input  logic [WORD_WIDTH-1:0]                    data_in_v1,
   output logic                                     data_in_v1_full,
   input  logic                                     data_in_v2_en,
   input  logic [WORD_WIDTH-1:0]                    data_in_v2,
   output logic                                     data_in_v2_full,
   input  logic                                     data_out_en,
   output logic [2*WORD_WIDTH+HSP_BANDS_WIDTH-1:0]  data_out,
   output logic                                     data_out_empty,
   input  logic [HSP_BANDS_WIDTH-1:0]               vector_length,
   input  hsid_op_e                                 mode,
   input  logic                                     acc_en,
   input  logic                                     start,
   output logic                                     done,
   output logic                                     idle,
   output logic                                     ready
);

   localparam int OUT_WIDTH = 2*WORD_WIDTH + HSP_BANDS_WIDTH;
   localparam int CNT_W     = HSP_BANDS_WIDTH + 1;
   localparam int DEPTH     = 2 ** BUFFER_WIDTH;
   localparam int OCC_W     = BUFFER_WIDTH + 1;

   // Element-wise result at full output width. The difference is formed as a
   // signed value one bit wider than the operands, then sign-extended, so
   // SUB wraps as two's complement and SQ_DIFF is exact.
   function automatic logic [OUT_WIDTH-1:0] op_result(
      input hsid_op_e              op,
      input logic [WORD_WIDTH-1:0] a,
      input logic [WORD_WIDTH-1:0] b
   );
      logic signed [WORD_WIDTH:0]  diff;
      logic signed [OUT_WIDTH-1:0] diff_x;
      logic [OUT_WIDTH-1:0]        r;
      diff   = $signed({1'b0, a}) - $signed({1'b0, b});
      diff_x = OUT_WIDTH'(diff);
      unique case (op)
         HSID_OP_ADD:      r = OUT_WIDTH'(a) + OUT_WIDTH'(b);
         HSID_OP_SUB:      r = diff_x;
         HSID_OP_ABS_DIFF: r = diff_x[OUT_WIDTH-1] ? -diff_x : diff_x;
         HSID_OP_SQ_DIFF:  r = diff_x * diff_x;
         default:          r = '0;
      endcase
      return r;
   endfunction

   // Length field 0 stands for the full 2**HSP_BANDS_WIDTH elements.
   function automatic logic [CNT_W-1:0] decode_len(
      input logic [HSP_BANDS_WIDTH-1:0] len
   );
      logic [CNT_W-1:0] r;
      if (len == '0) begin
         r = {1'b1, {HSP_BANDS_WIDTH{1'b0}}};
      end else begin
         r = {1'b0, len};
      end
      return r;
   endfunction

   hsid_state_e           state_q, state_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   hsid_op_e              mode_q, mode_d;
   logic                  acc_en_q, acc_en_d;
   logic [OUT_WIDTH-1:0]  acc_q, acc_d;
   logic [OCC_W-1:0]      out_occ_q, out_occ_d;
   logic                  vld_p0_q, vld_p0_d;
   logic                  last_p0_q, last_p0_d;

   logic [WORD_WIDTH-1:0] v1_head;
   logic [WORD_WIDTH-1:0] v2_head;
   logic                  v1_empty;
   logic                  v2_empty;
   logic                  out_full;
   logic                  out_empty;

   logic                  start_ok;
   logic                  pop;
   logic                  out_rd;
   logic                  out_push;
   logic [OUT_WIDTH-1:0]  res_p1;
   logic [OUT_WIDTH-1:0]  acc_sum_p1;
   logic [OUT_WIDTH-1:0]  out_wdata_p1;

   hsid_fifo #(
      .WIDTH  (WORD_WIDTH),
      .ADDR_W (BUFFER_WIDTH)
   ) u_fifo_v1 (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (data_in_v1_en),
      .wr_data_i (data_in_v1),
      .rd_en_i   (pop),
      .rd_data_o (v1_head),
      .full_o    (data_in_v1_full),
      .empty_o   (v1_empty)
   );

   hsid_fifo #(
      .WIDTH  (WORD_WIDTH),
      .ADDR_W (BUFFER_WIDTH)
   ) u_fifo_v2 (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (data_in_v2_en),
      .wr_data_i (data_in_v2),
      .rd_en_i   (pop),
      .rd_data_o (v2_head),
      .full_o    (data_in_v2_full),
      .empty_o   (v2_empty)
   );

   hsid_fifo #(
      .WIDTH  (OUT_WIDTH),
      .ADDR_W (BUFFER_WIDTH)
   ) u_fifo_out (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (out_push),
      .wr_data_i (out_wdata_p1),
      .rd_en_i   (data_out_en),
      .rd_data_o (data_out),
      .full_o    (out_full),
      .empty_o   (out_empty)
   );

   assign data_out_empty = out_empty;
   assign out_rd         = data_out_en && !out_empty;
   assign start_ok       = (state_q == HSID_ST_IDLE) && start;

   // Stage p0: pop one operand pair into the input FIFO read registers.
   // A pop is only issued when the output FIFO can absorb every result that
   // is already in flight plus this one, so nothing stalls past the pop.
   assign pop = (state_q == HSID_ST_COMPUTE) && !v1_empty && !v2_empty &&
                (cnt_q < len_q) && !out_full &&
                ((out_occ_q + OCC_W'(vld_p0_q)) < OCC_W'(DEPTH));

   // Stage p1: compute from the popped operands and push to the output FIFO.
   // In reduction mode only the element tagged last pushes, carrying the sum.
   assign res_p1       = op_result(mode_q, v1_head, v2_head);
   assign acc_sum_p1   = acc_q + res_p1;
   assign out_wdata_p1 = acc_en_q ? acc_sum_p1 : res_p1;
   assign out_push     = vld_p0_q && (!acc_en_q || last_p0_q);

   always_comb begin
      state_d = state_q;
      idle    = 1'b0;
      ready   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         HSID_ST_IDLE: begin
            idle  = 1'b1;
            ready = 1'b1;
            if (start) begin
               state_d = HSID_ST_COMPUTE;
            end
         end
         HSID_ST_COMPUTE: begin
            if ((cnt_q == len_q) && !vld_p0_q) begin
               state_d = HSID_ST_DONE;
            end
         end
         HSID_ST_DONE: begin
            done = 1'b1;
            if (out_empty) begin
               state_d = HSID_ST_IDLE;
            end
         end
         default: begin
            state_d = HSID_ST_IDLE;
         end
      endcase
   end

   always_comb begin
      len_d     = len_q;
      mode_d    = mode_q;
      acc_en_d  = acc_en_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      vld_p0_d  = pop;
      last_p0_d = pop && ((cnt_q + CNT_W'(1)) == len_q);
      out_occ_d = out_occ_q + OCC_W'(out_push) - OCC_W'(out_rd);
      if (start_ok) begin
         len_d    = decode_len(vector_length);
         mode_d   = mode;
         acc_en_d = acc_en;
         cnt_d    = '0;
         acc_d    = '0;
      end else begin
         if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (vld_p0_q && acc_en_q) begin
            acc_d = acc_sum_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HSID_ST_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= HSID_OP_ADD;
         acc_en_q  <= 1'b0;
         acc_q     <= '0;
         out_occ_q <= '0;
         vld_p0_q  <= 1'b0;
         last_p0_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         acc_en_q  <= acc_en_d;
         acc_q     <= acc_d;
         out_occ_q <= out_occ_d;
         vld_p0_q  <= vld_p0_d;
         last_p0_q <= last_p0_d;
      end
   end

endmodule
